// File: rtl/counter_nbit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : counter_pkg
//  Description : Constants and helpers shared by the counter_nbit family.
//                - CNT_WRAP / CNT_SAT : bound behaviour selector (SATURATE)
//                - CNT_DN / CNT_UP    : direction encoding of the UP input
//                - cnt_default_max()  : largest count a WIDTH-bit counter holds
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  localparam logic CNT_DN   = 1'b0;
  localparam logic CNT_UP   = 1'b1;

  // Evaluated in 64 bits so that WIDTH=32 yields 2**32-1 without overflow.
  function automatic longint cnt_default_max(input int width);
    return (longint'(1) << width) - longint'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_nbit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : counter_nbit_if
//  Description : Control and status bundle of one counter_nbit instance.
//                master : the controlling logic (drives CLR/EN/UP/LD/D_IN)
//                slave  : the counter itself (drives Q_OUT/TC/CO/EVT/OVF)
//  Signals     : CLR   synchronous clear        EN    count enable
//                UP    1=increment, 0=decrement  LD    synchronous load
//                D_IN  load value [WIDTH]        Q_OUT registered count
//                TC    terminal count            CO    cascade carry TC&EN
//                EVT   bound-hit pulse           OVF   sticky bound-hit flag
//  Revision    : 1.0  initial release
// ============================================================================
interface counter_nbit_if #(
  parameter int WIDTH = 6
);

  logic             CLR;
  logic             EN;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D_IN;
  logic [WIDTH-1:0] Q_OUT;
  logic             TC;
  logic             CO;
  logic             EVT;
  logic             OVF;

  modport master (
    output CLR, EN, UP, LD, D_IN,
    input  Q_OUT, TC, CO, EVT, OVF
  );

  modport slave (
    input  CLR, EN, UP, LD, D_IN,
    output Q_OUT, TC, CO, EVT, OVF
  );

endinterface
`default_nettype wire

// File: rtl/counter_nbit_next.sv
`default_nettype none
// ============================================================================
//  Module      : counter_next
//  Description : Combinational next-count logic of counter_nbit. Given the
//                current count, direction and enable it returns the value the
//                count takes on the next edge, the terminal-count flag and
//                whether that edge hits a bound.
//  Ports       : q_i     current count [WIDTH]
//                up_i    direction (1=up, 0=down)
//                en_i    count enable
//                next_o  next count [WIDTH]
//                tc_o    terminal count for the current direction
//                hit_o   enabled count while at the terminal value
//  Revision    : 1.0  initial release
// ============================================================================
module counter_next
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 6,
  parameter longint MAX_VAL  = cnt_default_max(WIDTH),
  parameter int     SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o,
  output logic             hit_o
);

  localparam logic [WIDTH:0] C_MAX     = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] C_ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_inc_ext;
  logic           w_at_top;
  logic           w_at_bot;

  // The increment is formed one bit wider than the count so that the top
  // comparison sees the true sum even when MAX_VAL is 2**WIDTH-1.
  assign w_q_ext   = {1'b0, q_i};
  assign w_inc_ext = w_q_ext + C_ONE_EXT;
  assign w_at_top  = (w_inc_ext > C_MAX);
  assign w_at_bot  = (q_i == '0);

  assign tc_o  = (up_i == CNT_UP) ? w_at_top : w_at_bot;
  assign hit_o = en_i & tc_o;

  always_comb begin
    next_o = q_i;
    if (en_i) begin
      if (up_i == CNT_UP) begin
        if (!w_at_top) begin
          next_o = w_inc_ext[WIDTH-1:0];
        end else if (SATURATE == CNT_WRAP) begin
          next_o = '0;
        end
      end else begin
        if (!w_at_bot) begin
          next_o = q_i - C_ONE;
        end else if (SATURATE == CNT_WRAP) begin
          next_o = C_MAX[WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : counter_nbit
//  Description : Parametrised up/down counter with synchronous clear, parallel
//                load (clamped to MAX_VAL), wrap-or-saturate bound handling and
//                cascade outputs. Edge priority is CLR > LD > EN.
//  Ports       : CLK    rising-edge clock
//                CLR_N  asynchronous active-low reset
//                bus    counter_nbit_if.slave (CLR, EN, UP, LD, D_IN in;
//                       Q_OUT, TC, CO, EVT, OVF out)
//  Revision    : 1.0  initial release
// ============================================================================
module counter_nbit
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 6,
  parameter longint MAX_VAL   = cnt_default_max(WIDTH),
  parameter int     SATURATE  = CNT_WRAP,
  parameter longint RESET_VAL = 0
) (
  input  logic           CLK,
  input  logic           CLR_N,
  counter_nbit_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Parameter legality, rejected while elaborating
  // --------------------------------------------------------------------------
  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("counter_nbit: WIDTH=%0d outside 1..32", WIDTH);
  end
  if ((MAX_VAL <= 0) || (MAX_VAL > cnt_default_max(WIDTH))) begin : g_bad_max
    $error("counter_nbit: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
  end
  if ((RESET_VAL < 0) || (RESET_VAL > MAX_VAL)) begin : g_bad_reset
    $error("counter_nbit: RESET_VAL=%0d outside 0..MAX_VAL", RESET_VAL);
  end
  if ((SATURATE != CNT_WRAP) && (SATURATE != CNT_SAT)) begin : g_bad_sat
    $error("counter_nbit: SATURATE=%0d must be 0 or 1", SATURATE);
  end

  localparam logic [WIDTH:0]   C_MAX   = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] C_RESET = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             evt_q;
  logic             evt_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] w_cnt_next;
  logic             w_tc;
  logic             w_hit;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i    (q_q),
    .up_i   (bus.UP),
    .en_i   (bus.EN),
    .next_o (w_cnt_next),
    .tc_o   (w_tc),
    .hit_o  (w_hit)
  );

  // EVT only reports the edge that actually counted through a bound, so it
  // drops on every other edge, including idle ones.
  always_comb begin
    q_d   = q_q;
    evt_d = 1'b0;
    ovf_d = ovf_q;
    if (bus.CLR) begin
      q_d   = C_RESET;
      ovf_d = 1'b0;
    end else if (bus.LD) begin
      // Out-of-range load values are clamped so Q_OUT never exceeds MAX_VAL.
      q_d   = ({1'b0, bus.D_IN} > C_MAX) ? C_MAX[WIDTH-1:0] : bus.D_IN;
      ovf_d = 1'b0;
    end else begin
      q_d   = w_cnt_next;
      evt_d = w_hit;
      ovf_d = ovf_q | w_hit;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      q_q   <= C_RESET;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q_OUT = q_q;
  assign bus.TC    = w_tc;
  assign bus.CO    = w_tc & bus.EN;
  assign bus.EVT   = evt_q;
  assign bus.OVF   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_nbit
//  Description : Self-checking bench for counter_nbit. Three instances share
//                one stimulus stream:
//                  0: WIDTH=4 MAX_VAL=9  wrap      RESET_VAL=0
//                  1: WIDTH=4 MAX_VAL=9  saturate  RESET_VAL=0
//                  2: WIDTH=5 MAX_VAL=31 wrap      RESET_VAL=7
//                A behavioural integer model tracks each instance and is
//                compared on every falling clock edge; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_nbit;
  import counter_pkg::*;

  localparam int NDUT = 3;
  localparam int MAXV [NDUT] = '{9, 9, 31};
  localparam int SATV [NDUT] = '{0, 1, 0};
  localparam int RSTV [NDUT] = '{0, 0, 7};

  int n_tests = 0;
  int n_fail  = 0;

  logic       CLK   = 1'b0;
  logic       CLR_N = 1'b0;
  logic       clr, ld, en, up;
  logic [4:0] din;
  bit         chk_on = 1'b0;

  always #5 CLK = ~CLK;

  counter_nbit_if #(.WIDTH(4)) if_w ();
  counter_nbit_if #(.WIDTH(4)) if_s ();
  counter_nbit_if #(.WIDTH(5)) if_b ();

  assign if_w.CLR = clr;  assign if_w.LD = ld;  assign if_w.EN = en;
  assign if_w.UP  = up;   assign if_w.D_IN = din[3:0];
  assign if_s.CLR = clr;  assign if_s.LD = ld;  assign if_s.EN = en;
  assign if_s.UP  = up;   assign if_s.D_IN = din[3:0];
  assign if_b.CLR = clr;  assign if_b.LD = ld;  assign if_b.EN = en;
  assign if_b.UP  = up;   assign if_b.D_IN = din;

  counter_nbit #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_WRAP), .RESET_VAL(0)) u_wrap (
    .CLK(CLK), .CLR_N(CLR_N), .bus(if_w));
  counter_nbit #(.WIDTH(4), .MAX_VAL(9), .SATURATE(CNT_SAT), .RESET_VAL(0)) u_sat (
    .CLK(CLK), .CLR_N(CLR_N), .bus(if_s));
  counter_nbit #(.WIDTH(5), .SATURATE(CNT_WRAP), .RESET_VAL(7)) u_big (
    .CLK(CLK), .CLR_N(CLR_N), .bus(if_b));

  logic [31:0] dq   [NDUT];
  logic        dtc  [NDUT];
  logic        dco  [NDUT];
  logic        devt [NDUT];
  logic        dovf [NDUT];

  assign dq[0] = 32'(if_w.Q_OUT);  assign dq[1] = 32'(if_s.Q_OUT);  assign dq[2] = 32'(if_b.Q_OUT);
  assign dtc[0]  = if_w.TC;  assign dtc[1]  = if_s.TC;  assign dtc[2]  = if_b.TC;
  assign dco[0]  = if_w.CO;  assign dco[1]  = if_s.CO;  assign dco[2]  = if_b.CO;
  assign devt[0] = if_w.EVT; assign devt[1] = if_s.EVT; assign devt[2] = if_b.EVT;
  assign dovf[0] = if_w.OVF; assign dovf[1] = if_s.OVF; assign dovf[2] = if_b.OVF;

  // --------------------------------------------------------------------------
  // Behavioural model: plain integers, rules taken straight from the counter's
  // definition (clear, clamped load, count with wrap or hold at the bound).
  // --------------------------------------------------------------------------
  int mq   [NDUT];
  bit mevt [NDUT];
  bit movf [NDUT];

  function automatic bit m_tc(input int q, input int mx, input bit u);
    return u ? (q == mx) : (q == 0);
  endfunction

  function automatic int m_step(input int i, input int q, input bit u);
    if (u) return (q == MAXV[i]) ? ((SATV[i] != 0) ? q : 0) : q + 1;
    return (q == 0) ? ((SATV[i] != 0) ? q : MAXV[i]) : q - 1;
  endfunction

  function automatic int m_din(input int i);
    return (i == 2) ? int'(din) : int'(din[3:0]);
  endfunction

  always @(posedge CLK or negedge CLR_N) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!CLR_N) begin
        mq[i] <= RSTV[i];  mevt[i] <= 1'b0;  movf[i] <= 1'b0;
      end else if (clr) begin
        mq[i] <= RSTV[i];  mevt[i] <= 1'b0;  movf[i] <= 1'b0;
      end else if (ld) begin
        mq[i]   <= (m_din(i) > MAXV[i]) ? MAXV[i] : m_din(i);
        mevt[i] <= 1'b0;
        movf[i] <= 1'b0;
      end else if (en) begin
        mq[i]   <= m_step(i, mq[i], up);
        mevt[i] <= m_tc(mq[i], MAXV[i], up);
        movf[i] <= movf[i] | m_tc(mq[i], MAXV[i], up);
      end else begin
        mevt[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT comparison on every falling edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("cmp_q[%0d]",   i), dq[i],          32'(mq[i]));
        chk($sformatf("cmp_tc[%0d]",  i), 32'(dtc[i]),    32'(m_tc(mq[i], MAXV[i], up)));
        chk($sformatf("cmp_co[%0d]",  i), 32'(dco[i]),    32'(m_tc(mq[i], MAXV[i], up) & en));
        chk($sformatf("cmp_evt[%0d]", i), 32'(devt[i]),   32'(mevt[i]));
        chk($sformatf("cmp_ovf[%0d]", i), 32'(dovf[i]),   32'(movf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  localparam int P1W [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  localparam int P1S [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};

  initial begin
    clr = 1'b0; ld = 1'b0; en = 1'b0; up = CNT_UP; din = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q_wrap", dq[0], 32'd0);
    chk("rst_q_big",  dq[2], 32'd7);
    chk("rst_evt",    32'(devt[0]), 32'd0);
    chk("rst_ovf",    32'(dovf[0]), 32'd0);
    #2 CLR_N = 1'b1;
    chk_on = 1'b1;

    // Count up 12 edges: wrap instance 1..9,0,1,2; saturating one holds at 9
    en = 1'b1; up = CNT_UP;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("p1_q_wrap[%0d]", k), dq[0], 32'(P1W[k]));
      chk($sformatf("p1_q_sat[%0d]",  k), dq[1], 32'(P1S[k]));
      chk($sformatf("p1_tc_wrap[%0d]", k), 32'(dtc[0]), (P1W[k] == 9) ? 32'd1 : 32'd0);
      chk($sformatf("p1_evt_wrap[%0d]", k), 32'(devt[0]), (k == 9) ? 32'd1 : 32'd0);
      chk($sformatf("p1_evt_sat[%0d]",  k), 32'(devt[1]), (k >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("p1_ovf_wrap[%0d]", k), 32'(dovf[0]), (k >= 9) ? 32'd1 : 32'd0);
    end

    // Count down through zero
    ld = 1'b1; en = 1'b0; din = 5'd0;
    tick();
    ld = 1'b0; up = CNT_DN;
    #1;
    chk("p3_tc_at0",     32'(dtc[0]), 32'd1);
    chk("p3_co_en0",     32'(dco[0]), 32'd0);
    en = 1'b1;
    #1;
    chk("p3_co_en1",     32'(dco[0]), 32'd1);
    tick();
    chk("p3_q_wrap_9",   dq[0], 32'd9);
    chk("p3_q_sat_0",    dq[1], 32'd0);
    chk("p3_co_after",   32'(dco[0]), 32'd0);
    tick();
    chk("p3_q_wrap_8",   dq[0], 32'd8);

    // Load clamp and load-over-count priority
    ld = 1'b1; en = 1'b0; din = 5'd14;
    tick();
    chk("p4_q_clamp",    dq[0], 32'd9);
    chk("p4_ovf_clr",    32'(dovf[0]), 32'd0);
    chk("p4_q_big_14",   dq[2], 32'd14);
    en = 1'b1; din = 5'd3; up = CNT_UP;
    tick();
    chk("p4_q_ld_en",    dq[0], 32'd3);

    // Clear beats load and count
    din = 5'd5; en = 1'b0;
    tick();
    clr = 1'b1; en = 1'b1; din = 5'd12;
    tick();
    chk("p5_q_wrap_rst", dq[0], 32'd0);
    chk("p5_q_big_rst",  dq[2], 32'd7);
    chk("p5_ovf",        32'(dovf[0]), 32'd0);

    // Asynchronous reset between edges
    clr = 1'b0; ld = 1'b1; en = 1'b0; din = 5'd6;
    tick();
    ld = 1'b0; en = 1'b1; up = CNT_UP;
    tick();
    chk("p6_q_7",        dq[0], 32'd7);
    #1 CLR_N = 1'b0;
    #1;
    chk("p6_async_q",    dq[0], 32'd0);
    chk("p6_async_big",  dq[2], 32'd7);
    #3 CLR_N = 1'b1;
    tick();
    chk("p6_resume",     dq[0], 32'd1);

    // Randomised traffic, including occasional async resets between edges
    for (int k = 0; k < 800; k++) begin
      clr = ($urandom_range(0, 29) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) up = ~up;
      din = 5'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #1 CLR_N = 1'b0;
        #1 CLR_N = 1'b1;
      end
      tick();
    end

    chk_on = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_nbit.md
Name: counter_nbit

Overview:
- Parametrised successor to the fixed 6-bit enable/clear counter.
- Generalised in width and modulus, with up/down direction, parallel load, and a wrap-or-saturate mode.
- Provides terminal-count and carry outputs so instances cascade into wider or multi-digit counters.
- Used in the notepad datapath for cursor, line and timer counting.

Parameters:
- WIDTH, 6: counter width in bits. Legal range 1..32.
- MAX_VAL, 2**WIDTH-1: upper bound of the count range 0..MAX_VAL. Must satisfy 0 < MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: bound behaviour. 0 = wrap (modulo MAX_VAL+1); 1 = hold at the bound.
- RESET_VAL, 0: value loaded by CLR_N and CLR. Must be <= MAX_VAL.

Ports:
- CLK  in  1  rising-edge clock.
- CLR_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear, active-high.
- EN  in  1  count enable.
- UP  in  1  direction. 1 = increment, 0 = decrement.
- LD  in  1  synchronous parallel load.
- D_IN  in  WIDTH  load value.
- Q_OUT  out  WIDTH  registered count.
- TC  out  1  terminal count (combinational from Q_OUT and UP).
- CO  out  1  cascade carry (combinational): TC & EN.
- EVT  out  1  registered pulse: the previous cycle hit a bound (wrap or saturate).
- OVF  out  1  registered sticky flag: a bound has been hit since the last clear or load.

Behaviour:
- Interface (already decided): one clock, CLK. Reset CLR_N is asynchronous and active-low.
- CLR_N low: immediately Q_OUT=RESET_VAL, EVT=0, OVF=0, independent of CLK. Release is synchronised externally; the first counting edge follows release.
- Per-edge priority: CLR > LD > EN. With none asserted, all registers hold.
- CLR=1:
  - Q_OUT<=RESET_VAL, EVT<=0, OVF<=0.
  - LD and EN are ignored.
- LD=1 (CLR=0):
  - Q_OUT<=D_IN if D_IN<=MAX_VAL, else Q_OUT<=MAX_VAL (clamp).
  - EVT<=0, OVF<=0. EN is ignored.
- EN=1, UP=1:
  - Q_OUT<MAX_VAL: Q_OUT<=Q_OUT+1.
  - Q_OUT==MAX_VAL, SATURATE=0: Q_OUT<=0.
  - Q_OUT==MAX_VAL, SATURATE=1: Q_OUT holds.
- EN=1, UP=0:
  - Q_OUT>0: Q_OUT<=Q_OUT-1.
  - Q_OUT==0, SATURATE=0: Q_OUT<=MAX_VAL.
  - Q_OUT==0, SATURATE=1: Q_OUT holds.
- Bound hit: an enabled count while TC=1. On that edge EVT<=1 and OVF<=1. On any edge without a bound hit, EVT<=0.
- TC = (UP & Q_OUT==MAX_VAL) | (~UP & Q_OUT==0). CO gates TC with EN, so tying an instance's EN to the lower stage's CO cascades correctly.
- Latency: count, load and clear all take effect on Q_OUT one edge after sampling. TC/CO respond to UP changes in the same cycle.
- Arithmetic:
  - Compare and increment at WIDTH+1 bits internally; no silent truncation.
  - Non-power-of-two MAX_VAL must never expose values above MAX_VAL on Q_OUT.
- Direction reversal mid-count is legal and takes effect on the next enabled edge.
- Illegal parameters (RESET_VAL>MAX_VAL, MAX_VAL>2**WIDTH-1, WIDTH outside 1..32) are rejected by an elaboration-time check.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants CNT_WRAP=0 and CNT_SAT=1;
  - direction constants CNT_DN=0 and CNT_UP=1;
  - a function computing the default MAX_VAL from WIDTH.
- One natural sub-module: counter_next. It is purely combinational, takes Q_OUT, UP and EN, and returns the next value and the bound-hit flag for the given MAX_VAL/SATURATE.
- counter_nbit keeps the registers, priority logic and flag logic.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0, UP=1, EN=1 from reset for 12 edges -> Q_OUT 1..9,0,1,2. TC=1 while Q_OUT=9. EVT high only on the cycle after 9->0. OVF=1 thereafter.
2. Same config with SATURATE=1 -> Q_OUT climbs to 9 and holds. EVT pulses on every enabled edge at 9; OVF=1.
3. UP=0 from Q_OUT=0, SATURATE=0 -> Q_OUT=9, then 8. CO=1 only while Q_OUT=0 and EN=1.
4. LD=1 with D_IN=14 (MAX_VAL=9) -> Q_OUT=9, OVF=0. LD=1 and EN=1 with D_IN=3 -> Q_OUT=3 (no count).
5. CLR=1, LD=1, EN=1 together at Q_OUT=5 -> Q_OUT=RESET_VAL, OVF=0.
6. CLR_N pulsed low between clock edges mid-count at Q_OUT=7 -> Q_OUT=0 before the next edge. Counting resumes at 1 on the first edge after release.
